// File: rtl/aurora_tx_pkg.sv
// Shared types, constants and beat-packing helpers for the Aurora TX test-frame generator.
package aurora_tx_pkg;

    localparam int DATA_W = 64;
    localparam int KEEP_W = DATA_W / 8;
    localparam int LEN_W  = 16;
    localparam int GAP_W  = 8;

    localparam logic [15:0] MAGIC = 16'hA55A;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAY,
        TAIL,
        GAP
    } state_t;

    function automatic logic [DATA_W-1:0] pack_header(
        input logic [15:0] magic,
        input logic [15:0] len,
        input logic [31:0] seq
    );
        return {magic, len, seq};
    endfunction

    function automatic logic [DATA_W-1:0] pack_payload(
        input logic [31:0] seq,
        input logic [31:0] idx
    );
        return {seq, idx};
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-beat registered AXI-stream output stage: a loaded beat holds until accepted,
// and a flush drops it without transferring.
module axis_out_reg #(
    parameter int DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic              r_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_last  <= i_last;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_valid = r_valid;

endmodule

// File: rtl/aurora_tx_frame_gen.sv
// Link-test traffic source for the Aurora 64B/66B user TX port: header, incrementing
// payload and XOR checksum tail, sent only while the channel is up.
module aurora_tx_frame_gen
    import aurora_tx_pkg::*;
(
    input  logic              SysClk,
    input  logic              Rst_n,
    input  logic              Channel_Up,
    input  logic              Enable,
    input  logic [LEN_W-1:0]  Frame_Len,
    input  logic [GAP_W-1:0]  Gap_Cycles,
    output logic [DATA_W-1:0] M_Axis_Tdata,
    output logic [KEEP_W-1:0] M_Axis_Tkeep,
    output logic              M_Axis_Tlast,
    output logic              M_Axis_Tvalid,
    input  logic              M_Axis_Tready,
    output logic [31:0]       Frame_Cnt,
    output logic              Frame_Done,
    output logic              Frame_Abort,
    output logic              Busy
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    state_t            r_state;
    logic [LEN_W-1:0]  r_len;
    logic [GAP_W-1:0]  r_gap;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [LEN_W-1:0]  r_idx;
    logic [31:0]       r_seq;
    logic [DATA_W-1:0] r_csum;
    logic [31:0]       r_frame_cnt;
    logic              r_done;
    logic              r_abort;

    state_t            w_state_nxt;
    logic [LEN_W-1:0]  w_len_nxt;
    logic [GAP_W-1:0]  w_gap_nxt;
    logic [GAP_W-1:0]  w_gap_cnt_nxt;
    logic [LEN_W-1:0]  w_idx_nxt;
    logic [31:0]       w_seq_nxt;
    logic [DATA_W-1:0] w_csum_nxt;
    logic [31:0]       w_cnt_nxt;
    logic              w_done_nxt;
    logic              w_abort_nxt;
    logic              w_load;
    logic              w_flush;
    logic [DATA_W-1:0] w_beat_data;
    logic              w_beat_last;

    logic              w_go;
    logic              w_accept;
    logic              w_tvalid;
    logic              w_in_frame;
    logic [LEN_W-1:0]  w_len_in;
    logic [31:0]       w_seq_inc;
    logic [DATA_W-1:0] w_pay_word;

    assign w_go       = Enable && Channel_Up;
    assign w_accept   = w_tvalid && M_Axis_Tready;
    assign w_in_frame = (r_state == HDR) || (r_state == PAY) || (r_state == TAIL);
    assign w_len_in   = (Frame_Len == '0) ? LEN_ONE : Frame_Len;
    assign w_seq_inc  = r_seq + 32'd1;
    assign w_pay_word = pack_payload(r_seq, {{(32-LEN_W){1'b0}}, r_idx});

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_len_nxt     = r_len;
        w_gap_nxt     = r_gap;
        w_gap_cnt_nxt = r_gap_cnt;
        w_idx_nxt     = r_idx;
        w_seq_nxt     = r_seq;
        w_csum_nxt    = r_csum;
        w_cnt_nxt     = r_frame_cnt;
        w_done_nxt    = 1'b0;
        w_abort_nxt   = 1'b0;
        w_load        = 1'b0;
        w_flush       = 1'b0;
        w_beat_data   = '0;
        w_beat_last   = 1'b0;

        if (w_in_frame && !Channel_Up) begin
            // Losing the channel drops the pending beat; seq is kept so the frame is resent.
            w_flush     = 1'b1;
            w_abort_nxt = 1'b1;
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        w_len_nxt   = w_len_in;
                        w_gap_nxt   = Gap_Cycles;
                        w_load      = 1'b1;
                        w_beat_data = pack_header(MAGIC, w_len_in, r_seq);
                        w_state_nxt = HDR;
                    end
                end
                HDR: begin
                    if (w_accept) begin
                        w_csum_nxt  = pack_header(MAGIC, r_len, r_seq);
                        w_idx_nxt   = '0;
                        w_load      = 1'b1;
                        w_beat_data = pack_payload(r_seq, 32'd0);
                        w_state_nxt = PAY;
                    end
                end
                PAY: begin
                    if (w_accept) begin
                        w_csum_nxt = r_csum ^ w_pay_word;
                        w_load     = 1'b1;
                        if (r_idx == r_len - LEN_ONE) begin
                            w_beat_data = r_csum ^ w_pay_word;
                            w_beat_last = 1'b1;
                            w_state_nxt = TAIL;
                        end else begin
                            w_idx_nxt   = r_idx + LEN_ONE;
                            w_beat_data = pack_payload(r_seq, {{(32-LEN_W){1'b0}}, r_idx + LEN_ONE});
                        end
                    end
                end
                TAIL: begin
                    if (w_accept) begin
                        w_done_nxt = 1'b1;
                        w_cnt_nxt  = r_frame_cnt + 32'd1;
                        w_seq_nxt  = w_seq_inc;
                        if (r_gap == '0 && w_go) begin
                            w_len_nxt   = w_len_in;
                            w_gap_nxt   = Gap_Cycles;
                            w_load      = 1'b1;
                            w_beat_data = pack_header(MAGIC, w_len_in, w_seq_inc);
                            w_state_nxt = HDR;
                        end else if (r_gap == '0) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_gap_cnt_nxt = r_gap;
                            w_state_nxt   = GAP;
                        end
                    end
                end
                GAP: begin
                    if (!Channel_Up) begin
                        w_state_nxt = IDLE;
                    end else if (r_gap_cnt == GAP_ONE) begin
                        if (w_go) begin
                            w_len_nxt   = w_len_in;
                            w_gap_nxt   = Gap_Cycles;
                            w_load      = 1'b1;
                            w_beat_data = pack_header(MAGIC, w_len_in, r_seq);
                            w_state_nxt = HDR;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt - GAP_ONE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_idx       <= '0;
            r_seq       <= '0;
            r_csum      <= '0;
            r_frame_cnt <= '0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_gap       <= w_gap_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_seq       <= w_seq_nxt;
            r_csum      <= w_csum_nxt;
            r_frame_cnt <= w_cnt_nxt;
            r_done      <= w_done_nxt;
            r_abort     <= w_abort_nxt;
        end
    end

    axis_out_reg #(
        .DATA_W (DATA_W)
    ) u_out (
        .i_clk   (SysClk),
        .i_rst_n (Rst_n),
        .i_flush (w_flush),
        .i_load  (w_load),
        .i_data  (w_beat_data),
        .i_last  (w_beat_last),
        .i_ready (M_Axis_Tready),
        .o_data  (M_Axis_Tdata),
        .o_last  (M_Axis_Tlast),
        .o_valid (w_tvalid)
    );

    assign M_Axis_Tvalid = w_tvalid;
    assign M_Axis_Tkeep  = {KEEP_W{w_tvalid}};
    assign Frame_Cnt     = r_frame_cnt;
    assign Frame_Done    = r_done;
    assign Frame_Abort   = r_abort;
    assign Busy          = (r_state != IDLE);

endmodule

// File: doc/aurora_tx_frame_gen.md
Name: aurora_tx_frame_gen

Overview:
- Link-test traffic source: the AXI4-Stream master that drives the Aurora 64B/66B core's user TX port (s_axi_tx_*) on one lane.
- Builds framed test packets (header, incrementing payload, XOR checksum tail) and sends them only while the channel is up.
- Its output is the transmit-side counterpart of the IP's RX stream, so a far-end checker can verify the link.
- SysClk connects to the core's user_clk_x. Rst_n is driven from the inverted user_reset_x OR the system reset.

Parameters:
- DATA_W, 64, stream data width; fixed to match the core.
- KEEP_W, 8, DATA_W/8.
- LEN_W, 16, width of the payload-length field.
- GAP_W, 8, width of the inter-frame gap counter.
- MAGIC, 16'hA55A, header marker.

Ports:
- SysClk  in  1  user clock; all logic in this single domain.
- Rst_n  in  1  asynchronous, active-low reset.
- Channel_Up  in  1  core channel_up for this lane.
- Enable  in  1  level; frames are generated while high.
- Frame_Len  in  LEN_W  payload words per frame; 0 is treated as 1.
- Gap_Cycles  in  GAP_W  idle cycles between frames.
- M_Axis_Tdata  out  DATA_W  to s_axi_tx_tdata.
- M_Axis_Tkeep  out  KEEP_W  to s_axi_tx_tkeep.
- M_Axis_Tlast  out  1  to s_axi_tx_tlast.
- M_Axis_Tvalid  out  1  to s_axi_tx_tvalid.
- M_Axis_Tready  in  1  from s_axi_tx_tready.
- Frame_Cnt  out  32  completed frames, wraps at 2^32.
- Frame_Done  out  1  one-cycle pulse when a tail beat is accepted.
- Frame_Abort  out  1  one-cycle pulse when a frame is aborted.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): all outputs are 0, state = IDLE, sequence number = 0, checksum = 0. Frame_Cnt = 0.
- All AXI outputs are registered. A beat transfers on Tvalid & Tready.
- Once Tvalid is high, Tdata, Tkeep and Tlast hold stable until the beat transfers, except on abort.
- Tkeep = all-ones on every beat. Tvalid never depends combinationally on Tready.
- State machine: IDLE -> HDR -> PAY -> TAIL -> GAP -> (HDR or IDLE).
- IDLE:
  - When Enable & Channel_Up: latch len = max(Frame_Len, 1) and gap = Gap_Cycles.
  - Drive the header beat and go to HDR. Tvalid rises in the cycle after the condition is seen.
- Header beat: Tdata = {MAGIC[15:0], len[15:0], seq[31:0]}, Tlast = 0.
- HDR: on accept, go to PAY with idx = 0. Checksum = header word.
- PAY:
  - Beat i carries Tdata = {seq, i[31:0]}, Tlast = 0.
  - On accept: checksum ^= word, idx++.
  - After the accept with idx == len-1, go to TAIL.
- TAIL:
  - Tdata = checksum (XOR of header and all payload words), Tlast = 1.
  - On accept: pulse Frame_Done, Frame_Cnt++, seq++ (wraps).
  - If gap == 0 and Enable & Channel_Up, go straight to HDR; the next header is valid the following cycle.
  - Else if gap == 0, go to IDLE.
  - Else go to GAP.
- GAP:
  - Tvalid = 0 for exactly gap cycles.
  - Then go to HDR if Enable & Channel_Up, else IDLE. New len and gap values are latched at that point.
- Enable falling mid-frame: the current frame completes normally, then the block returns to IDLE.
- Channel_Up falling in HDR, PAY or TAIL:
  - Tvalid drops the next cycle and Frame_Abort pulses.
  - State goes to IDLE. seq and Frame_Cnt are unchanged; the aborted seq is reused.
  - Channel_Up low in GAP goes to IDLE with no abort.
- Frame_Len or Gap_Cycles changing mid-frame has no effect until the next latch point.
- Tready held low indefinitely: the block stalls with no beat loss and no counter change.
- Busy = (state != IDLE).

Decomposition:
- Package aurora_tx_pkg:
  - state enum typedef (IDLE, HDR, PAY, TAIL, GAP);
  - MAGIC constant;
  - header-pack function {magic, len, seq};
  - payload-word function {seq, idx}.
- Sub-module axis_out_reg:
  - single-beat registered AXI-stream output stage (data/last/valid hold-until-ready, with a flush input used for abort);
  - reusable by the RX-side checker's loopback path.

Test Plan:
- Frame_Len=3, Gap=2, Tready=1:
  - beats are A55A_0003_00000000, 00000000_00000000, 00000000_00000001, 00000000_00000002;
  - then the tail = XOR of those words, with Tlast=1;
  - then 2 idle cycles; the next header carries seq=1 and Frame_Cnt=1.
- Frame_Len=0: the frame has one payload beat (the len field reads 0001), the tail follows, and Frame_Done pulses once.
- Tready toggling 1010… over a Frame_Len=4 frame: Tdata and Tlast stay stable while stalled, and all 6 beats arrive in order with the correct checksum.
- Channel_Up deasserted on payload beat 2 of 5:
  - Tvalid=0 the next cycle, Frame_Abort=1 for one cycle, Frame_Cnt unchanged;
  - after Channel_Up returns, the next header reuses the same seq.
- Gap=0, Enable held:
  - the next header is valid the cycle after the tail is accepted;
  - Enable dropped during payload lets the frame finish, then Busy=0.
- Rst_n asserted mid-PAY: all outputs are 0 immediately (async). After release, the first header carries seq=0.
